btb_set_assoc: RTL and testbench

BTB_SET_ASSOC -- requirements
Module: btb_set_assoc

---
 rtl/btb_pkg.sv | 20 ++
 rtl/btb_way.sv | 58 +++++
 rtl/btb_set_assoc.sv | 153 +++++++++++++++
 tb/tb_btb_set_assoc.sv | 135 +++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// Shared types and constants for the set-associative branch target buffer.
// The 2-bit counter encoding and its saturating update live here so every way agrees.
package btb_pkg;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT   = 2'b00;
  localparam cnt_t CNT_WNT   = 2'b01;
  localparam cnt_t CNT_WT    = 2'b10;
  localparam cnt_t CNT_ST    = 2'b11;
  localparam cnt_t CNT_ALLOC = CNT_WT;

  function automatic cnt_t next_cnt(input cnt_t cnt, input logic taken);
    cnt_t res;
    if (taken) res = (cnt == CNT_ST)  ? CNT_ST  : cnt + 2'd1;
    else       res = (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: per-set valid/tag/target/counter with FETCH_W lookup ports,
// a tag-compare port for the update path, and a single write port.
module btb_way
  import btb_pkg::*;
#(
  parameter int INDEX_LEN = 6,
  parameter int FETCH_W   = 2,
  parameter int TAG_W     = 30 - INDEX_LEN
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [FETCH_W-1:0][INDEX_LEN-1:0]  r_idx,
  input  logic [FETCH_W-1:0][TAG_W-1:0]      r_tag,
  output logic [FETCH_W-1:0]                 r_hit,
  output logic [FETCH_W-1:0][31:0]           r_tgt,
  output logic [FETCH_W-1:0][1:0]            r_cnt,
  input  logic [INDEX_LEN-1:0]               u_idx,
  input  logic [TAG_W-1:0]                   u_tag,
  output logic                               u_hit,
  output cnt_t                               u_cnt,
  input  logic                               we,
  input  logic                               w_tgt_en,
  input  logic [31:0]                        w_tgt,
  input  cnt_t                               w_cnt
);

  localparam int SETS = 1 << INDEX_LEN;

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_mem [SETS];
  logic [31:0]      tgt_mem [SETS];
  cnt_t             cnt_mem [SETS];

  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      r_hit[i] = valid[r_idx[i]] && (tag_mem[r_idx[i]] == r_tag[i]);
      r_tgt[i] = tgt_mem[r_idx[i]];
      r_cnt[i] = cnt_mem[r_idx[i]];
    end
    u_hit = valid[u_idx] && (tag_mem[u_idx] == u_tag);
    u_cnt = cnt_mem[u_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (we) valid[u_idx] <= 1'b1;
  end

  // Payload arrays are never reset; a cleared valid bit hides them.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[u_idx] <= u_tag;
      cnt_mem[u_idx] <= w_cnt;
      if (w_tgt_en) tgt_mem[u_idx] <= w_tgt;
    end
  end

endmodule

// File: rtl/btb_set_assoc.sv
// Set-associative BTB predicting FETCH_W consecutive slots per query with 2-bit
// direction counters and round-robin allocation; outputs are registered.
module btb_set_assoc
  import btb_pkg::*;
#(
  parameter int INDEX_LEN = 6,
  parameter int WAYS      = 2,
  parameter int FETCH_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    q_valid,
  input  logic [31:0]             q_pc,
  output logic                    p_valid,
  output logic [FETCH_W-1:0]      p_taken,
  output logic [32*FETCH_W-1:0]   p_target,
  input  logic                    u_valid,
  input  logic [31:0]             u_pc,
  input  logic [31:0]             u_target,
  input  logic                    u_taken
);

  localparam int SETS  = 1 << INDEX_LEN;
  localparam int TAG_W = 30 - INDEX_LEN;
  localparam int VW    = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [FETCH_W-1:0][31:0]          pc_p0;
  logic [FETCH_W-1:0][INDEX_LEN-1:0] idx_p0;
  logic [FETCH_W-1:0][TAG_W-1:0]     tag_p0;
  logic [FETCH_W-1:0]                hit_p0;
  logic [FETCH_W-1:0][31:0]          hit_tgt_p0;
  logic [FETCH_W-1:0][1:0]           hit_cnt_p0;
  logic [FETCH_W-1:0]                taken_p0;
  logic [FETCH_W-1:0][31:0]          target_p0;

  logic [FETCH_W-1:0]       r_hit [WAYS];
  logic [FETCH_W-1:0][31:0] r_tgt [WAYS];
  logic [FETCH_W-1:0][1:0]  r_cnt [WAYS];

  logic [INDEX_LEN-1:0] u_idx;
  logic [TAG_W-1:0]     u_tag;
  logic [WAYS-1:0]      u_hit;
  cnt_t                 u_cnt [WAYS];
  logic                 u_any;
  cnt_t                 u_hit_cnt;
  cnt_t                 w_cnt;
  logic [WAYS-1:0]      we;
  logic [VW-1:0]        victim;
  logic [VW-1:0]        vptr [SETS];

  logic                     vld_p1;
  logic [FETCH_W-1:0]       taken_p1;
  logic [FETCH_W-1:0][31:0] target_p1;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{q_pc[1:0], u_pc[1:0], pc_p0[0][1:0]};

  // Stage p0: per-slot address split and way lookup.
  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      pc_p0[i]  = q_pc + 32'(4 * i);
      idx_p0[i] = pc_p0[i][INDEX_LEN+1:2];
      tag_p0[i] = pc_p0[i][31:INDEX_LEN+2];
    end
  end

  assign u_idx = u_pc[INDEX_LEN+1:2];
  assign u_tag = u_pc[31:INDEX_LEN+2];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    btb_way #(
      .INDEX_LEN (INDEX_LEN),
      .FETCH_W   (FETCH_W),
      .TAG_W     (TAG_W)
    ) u_way (
      .clk      (clk),
      .rst      (rst),
      .r_idx    (idx_p0),
      .r_tag    (tag_p0),
      .r_hit    (r_hit[w]),
      .r_tgt    (r_tgt[w]),
      .r_cnt    (r_cnt[w]),
      .u_idx    (u_idx),
      .u_tag    (u_tag),
      .u_hit    (u_hit[w]),
      .u_cnt    (u_cnt[w]),
      .we       (we[w]),
      .w_tgt_en (u_taken),
      .w_tgt    (u_target),
      .w_cnt    (w_cnt)
    );
  end

  // At most one way hits per slot, so a priority pick equals an OR-merge.
  always_comb begin
    for (int i = 0; i < FETCH_W; i++) begin
      hit_p0[i]     = 1'b0;
      hit_tgt_p0[i] = '0;
      hit_cnt_p0[i] = '0;
      for (int w = 0; w < WAYS; w++) begin
        if (r_hit[w][i]) begin
          hit_p0[i]     = 1'b1;
          hit_tgt_p0[i] = r_tgt[w][i];
          hit_cnt_p0[i] = r_cnt[w][i];
        end
      end
      taken_p0[i]  = hit_p0[i] && hit_cnt_p0[i][1];
      target_p0[i] = taken_p0[i] ? hit_tgt_p0[i] : q_pc + 32'(4 * (FETCH_W + i));
    end
  end

  always_comb begin
    u_any     = |u_hit;
    u_hit_cnt = CNT_SNT;
    for (int w = 0; w < WAYS; w++) begin
      if (u_hit[w]) u_hit_cnt = u_cnt[w];
    end
    victim = vptr[u_idx];
    w_cnt  = u_any ? next_cnt(u_hit_cnt, u_taken) : CNT_ALLOC;
    for (int w = 0; w < WAYS; w++) begin
      we[w] = u_valid && !rst &&
              (u_any ? u_hit[w] : (u_taken && (victim == VW'(w))));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) vptr[s] <= '0;
    end else if (u_valid && !u_any && u_taken) begin
      vptr[u_idx] <= (victim == VW'(WAYS - 1)) ? '0 : victim + VW'(1);
    end
  end

  // Stage p1: registered prediction, held while no query arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      taken_p1  <= '0;
      target_p1 <= '0;
    end else begin
      vld_p1 <= q_valid;
      if (q_valid) begin
        taken_p1  <= taken_p0;
        target_p1 <= target_p0;
      end
    end
  end

  assign p_valid  = vld_p1;
  assign p_taken  = taken_p1;
  assign p_target = target_p1;

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed bench for btb_set_assoc (INDEX_LEN=6, WAYS=2, FETCH_W=2) with
// hand-computed expected predictions.
module tb_btb_set_assoc;

  logic        clk;
  logic        rst;
  logic        q_valid;
  logic [31:0] q_pc;
  logic        p_valid;
  logic [1:0]  p_taken;
  logic [63:0] p_target;
  logic        u_valid;
  logic [31:0] u_pc;
  logic [31:0] u_target;
  logic        u_taken;

  int total = 0;
  int bad   = 0;

  btb_set_assoc #(.INDEX_LEN(6), .WAYS(2), .FETCH_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .q_valid  (q_valid),
    .q_pc     (q_pc),
    .p_valid  (p_valid),
    .p_taken  (p_taken),
    .p_target (p_target),
    .u_valid  (u_valid),
    .u_pc     (u_pc),
    .u_target (u_target),
    .u_taken  (u_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    q_valid = 1'b0;
    u_valid = 1'b0;
  endtask

  task automatic update(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
    u_valid = 1'b1; u_pc = pc; u_target = tgt; u_taken = tk;
    step();
    idle();
  endtask

  task automatic query(input string tag, input logic [31:0] pc,
                       input logic [1:0] exp_tk, input logic [31:0] t0, input logic [31:0] t1);
    q_valid = 1'b1; q_pc = pc;
    step();
    idle();
    chk({tag, "_vld"}, {63'd0, p_valid}, 64'd1);
    chk({tag, "_tk"},  {62'd0, p_taken}, {62'd0, exp_tk});
    chk({tag, "_tgt"}, p_target, {t1, t0});
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; q_valid = 1'b0; q_pc = '0;
    u_valid = 1'b0; u_pc = '0; u_target = '0; u_taken = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_vld", {63'd0, p_valid}, 64'd0);
    chk("rst_tk",  {62'd0, p_taken}, 64'd0);
    chk("rst_tgt", p_target, 64'd0);

    query("cold", 32'h0000_1000, 2'b00, 32'h0000_1008, 32'h0000_100C);
    step();
    chk("hold_vld", {63'd0, p_valid}, 64'd0);
    chk("hold_tgt", p_target, {32'h0000_100C, 32'h0000_1008});
    query("wrap", 32'hFFFF_FFFC, 2'b00, 32'h0000_0004, 32'h0000_0008);

    // Taken allocation at 0x1004 lands in slot 1 of the 0x1000 group.
    update(32'h0000_1004, 32'h0000_2000, 1'b1);
    query("alloc", 32'h0000_1000, 2'b10, 32'h0000_1008, 32'h0000_2000);

    update(32'h0000_1004, 32'h0000_9999, 1'b0);
    update(32'h0000_1004, 32'h0000_9999, 1'b0);
    query("cnt00", 32'h0000_1000, 2'b00, 32'h0000_1008, 32'h0000_100C);
    update(32'h0000_1004, 32'h0000_2000, 1'b1);
    query("cnt01", 32'h0000_1000, 2'b00, 32'h0000_1008, 32'h0000_100C);
    update(32'h0000_1004, 32'h0000_2040, 1'b1);
    query("cnt10", 32'h0000_1000, 2'b10, 32'h0000_1008, 32'h0000_2040);

    // Reset wins over a same-cycle query.
    rst = 1'b1; q_valid = 1'b1; q_pc = 32'h0000_1000;
    step();
    rst = 1'b0; idle();
    chk("rst2_vld", {63'd0, p_valid}, 64'd0);
    chk("rst2_tk",  {62'd0, p_taken}, 64'd0);
    chk("rst2_tgt", p_target, 64'd0);
    query("postrst", 32'h0000_1000, 2'b00, 32'h0000_1008, 32'h0000_100C);

    update(32'h0000_1000, 32'h0000_7777, 1'b0);
    query("ntmiss", 32'h0000_1000, 2'b00, 32'h0000_1008, 32'h0000_100C);

    // Read-before-write: a query alongside the allocating update sees the old state.
    u_valid = 1'b1; u_pc = 32'h0000_1000; u_target = 32'h0000_3000; u_taken = 1'b1;
    query("rbw_same", 32'h0000_1000, 2'b00, 32'h0000_1008, 32'h0000_100C);
    query("rbw_next", 32'h0000_1000, 2'b01, 32'h0000_3000, 32'h0000_100C);

    // Three allocations into set 0 of a two-way cache evict the oldest.
    reset_pulse();
    update(32'h0000_1000, 32'h0000_A000, 1'b1);
    update(32'h0000_1100, 32'h0000_B000, 1'b1);
    update(32'h0000_1200, 32'h0000_C000, 1'b1);
    query("evict_1000", 32'h0000_1000, 2'b00, 32'h0000_1008, 32'h0000_100C);
    query("keep_1100",  32'h0000_1100, 2'b01, 32'h0000_B000, 32'h0000_110C);
    query("keep_1200",  32'h0000_1200, 2'b01, 32'h0000_C000, 32'h0000_120C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
